// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the ALU datapath micro-sequencer.
// Ops, FSM states, status bit positions, writeback conditions, function selects.
package alu_seq_ctrl_pkg;

    localparam logic [1:0] OP_ALU_RR = 2'd0;
    localparam logic [1:0] OP_ALU_RI = 2'd1;
    localparam logic [1:0] OP_LOAD   = 2'd2;
    localparam logic [1:0] OP_STORE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WB,
        S_BUS_IN,
        S_BUS_OUT
    } state_t;

    localparam int STAT_Z = 0;
    localparam int STAT_C = 1;
    localparam int STAT_N = 2;
    localparam int STAT_V = 3;

    localparam logic [1:0] COND_ALWAYS = 2'd0;
    localparam logic [1:0] COND_Z      = 2'd1;
    localparam logic [1:0] COND_NZ     = 2'd2;
    localparam logic [1:0] COND_C      = 2'd3;

    localparam logic [4:0] FS_MOVA = 5'h00;
    localparam logic [4:0] FS_INC  = 5'h01;
    localparam logic [4:0] FS_ADD  = 5'h02;
    localparam logic [4:0] FS_SUB  = 5'h05;
    localparam logic [4:0] FS_AND  = 5'h08;
    localparam logic [4:0] FS_OR   = 5'h0A;

endpackage

// File: rtl/alu_seq_ctrl_cond.sv
// Writeback condition evaluation against captured ALU flags.
// Used only when ALU_SEQ_COND_EN is defined.
module alu_seq_ctrl_cond
    import alu_seq_ctrl_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [1:0] cond,
    output logic       pass
);

    logic unused_nv;
    assign unused_nv = flags[STAT_N] ^ flags[STAT_V];

    always_comb begin
        pass = 1'b1;
        unique case (cond)
            COND_ALWAYS: pass = 1'b1;
            COND_Z:      pass = flags[STAT_Z];
            COND_NZ:     pass = !flags[STAT_Z];
            COND_C:      pass = flags[STAT_C];
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Micro-sequencer driving the register-file/ALU control word.
// Define ALU_SEQ_COND_EN for conditional (flag-qualified) writeback.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_fs,
    input  logic        cmd_c0,
    input  logic [4:0]  cmd_ra,
    input  logic [4:0]  cmd_rb,
    input  logic [4:0]  cmd_rd,
    input  logic [63:0] cmd_imm,
    input  logic [1:0]  cmd_cond,
    input  logic [3:0]  status,
    output logic [4:0]  addrA,
    output logic [4:0]  addrB,
    output logic [4:0]  addrR,
    output logic [4:0]  fs,
    output logic        c0,
    output logic        s,
    output logic [63:0] k,
    output logic        w,
    output logic        sb,
    output logic        sd,
    output logic        bus_in_req,
    output logic        bus_out_valid,
    output logic [3:0]  flags_q,
    output logic        done,
    output logic        skipped
);

    localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

    state_t      state, nxt;
    logic [3:0]  cnt, cnt_n;
    logic        acc;

    logic [1:0]  op_q;
    logic [4:0]  ra_q, rb_q, rd_q, fsel_q;
    logic        cin_q;
    logic [63:0] imm_q;

    logic [1:0]  op_l;
    logic [4:0]  ra_l, rb_l, rd_l, fsel_l;
    logic        cin_l;
    logic [63:0] imm_l;

    logic [3:0]  flags_d;
    logic        wb_ok;

    logic [4:0]  addrA_d, addrB_d, addrR_d, fs_d;
    logic        c0_d, s_d, w_d, sb_d, sd_d;
    logic [63:0] k_d;
    logic        bin_d, bout_d, ready_d, done_d, skip_d;

    assign acc = cmd_valid && cmd_ready;

    // Flags land on the final EXEC edge, so WB sees this op's status.
    assign flags_d = (state == S_EXEC && cnt == LAST) ? status : flags_q;

`ifdef ALU_SEQ_COND_EN
    logic [1:0] cond_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cond_q <= COND_ALWAYS;
        else if (acc) cond_q <= cmd_cond;
    end

    alu_seq_ctrl_cond u_cond (
        .flags (flags_d),
        .cond  (cond_q),
        .pass  (wb_ok)
    );
`else
    logic unused_cond;
    assign unused_cond = ^cmd_cond;
    assign wb_ok = 1'b1;
`endif

    always_comb begin
        op_l   = acc ? cmd_op  : op_q;
        ra_l   = acc ? cmd_ra  : ra_q;
        rb_l   = acc ? cmd_rb  : rb_q;
        rd_l   = acc ? cmd_rd  : rd_q;
        fsel_l = acc ? cmd_fs  : fsel_q;
        cin_l  = acc ? cmd_c0  : cin_q;
        imm_l  = acc ? cmd_imm : imm_q;

        nxt   = state;
        cnt_n = cnt;
        unique case (state)
            S_IDLE: begin
                if (acc) begin
                    cnt_n = 4'd0;
                    unique case (cmd_op)
                        OP_LOAD:  nxt = S_BUS_IN;
                        OP_STORE: nxt = S_BUS_OUT;
                        default:  nxt = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                if (cnt == LAST) nxt = S_WB;
                else             cnt_n = cnt + 4'd1;
            end
            S_WB, S_BUS_IN, S_BUS_OUT: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase

        addrA_d = '0;
        addrB_d = '0;
        addrR_d = '0;
        fs_d    = '0;
        c0_d    = 1'b0;
        s_d     = 1'b0;
        k_d     = '0;
        w_d     = 1'b0;
        sb_d    = 1'b0;
        sd_d    = 1'b0;
        bin_d   = 1'b0;
        bout_d  = 1'b0;
        ready_d = (nxt == S_IDLE);
        done_d  = (state == S_WB) || (state == S_BUS_IN) ||
                  (state == S_BUS_OUT);
        skip_d  = (state == S_WB) && !wb_ok;

        // Outputs are precomputed for the state being entered.
        unique case (nxt)
            S_EXEC, S_WB: begin
                addrA_d = ra_l;
                addrB_d = rb_l;
                fs_d    = fsel_l;
                c0_d    = cin_l;
                s_d     = (op_l == OP_ALU_RI);
                k_d     = s_d ? imm_l : '0;
                if (nxt == S_WB) begin
                    addrR_d = rd_l;
                    w_d     = wb_ok;
                    sd_d    = wb_ok;
                end
            end
            S_BUS_IN: begin
                addrR_d = rd_l;
                w_d     = 1'b1;
                bin_d   = 1'b1;
            end
            S_BUS_OUT: begin
                addrB_d = rb_l;
                sb_d    = 1'b1;
                bout_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= OP_ALU_RR;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            fsel_q <= '0;
            cin_q  <= 1'b0;
            imm_q  <= '0;
        end else if (acc) begin
            op_q   <= cmd_op;
            ra_q   <= cmd_ra;
            rb_q   <= cmd_rb;
            rd_q   <= cmd_rd;
            fsel_q <= cmd_fs;
            cin_q  <= cmd_c0;
            imm_q  <= cmd_imm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrA         <= '0;
            addrB         <= '0;
            addrR         <= '0;
            fs            <= '0;
            c0            <= 1'b0;
            s             <= 1'b0;
            k             <= '0;
            w             <= 1'b0;
            sb            <= 1'b0;
            sd            <= 1'b0;
            bus_in_req    <= 1'b0;
            bus_out_valid <= 1'b0;
            flags_q       <= '0;
            cmd_ready     <= 1'b1;
            done          <= 1'b0;
            skipped       <= 1'b0;
        end else begin
            addrA         <= addrA_d;
            addrB         <= addrB_d;
            addrR         <= addrR_d;
            fs            <= fs_d;
            c0            <= c0_d;
            s             <= s_d;
            k             <= k_d;
            w             <= w_d;
            sb            <= sb_d;
            sd            <= sd_d;
            bus_in_req    <= bin_d;
            bus_out_valid <= bout_d;
            flags_q       <= flags_d;
            cmd_ready     <= ready_d;
            done          <= done_d;
            skipped       <= skip_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (EXEC_CYCLES=2).
// Conditional-writeback expectations follow ALU_SEQ_COND_EN.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int EXEC = 2;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op, cmd_cond;
    logic [4:0]  cmd_fs, cmd_ra, cmd_rb, cmd_rd;
    logic        cmd_c0;
    logic [63:0] cmd_imm;
    logic [3:0]  status;
    logic [4:0]  addrA, addrB, addrR, fs;
    logic        c0, s, w, sb, sd;
    logic [63:0] k;
    logic        bus_in_req, bus_out_valid;
    logic [3:0]  flags_q;
    logic        done, skipped;

    int n_cmp = 0;
    int n_bad = 0;
    int sbsd_viol = 0;

    alu_seq_ctrl #(.EXEC_CYCLES(EXEC)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_fs        (cmd_fs),
        .cmd_c0        (cmd_c0),
        .cmd_ra        (cmd_ra),
        .cmd_rb        (cmd_rb),
        .cmd_rd        (cmd_rd),
        .cmd_imm       (cmd_imm),
        .cmd_cond      (cmd_cond),
        .status        (status),
        .addrA         (addrA),
        .addrB         (addrB),
        .addrR         (addrR),
        .fs            (fs),
        .c0            (c0),
        .s             (s),
        .k             (k),
        .w             (w),
        .sb            (sb),
        .sd            (sd),
        .bus_in_req    (bus_in_req),
        .bus_out_valid (bus_out_valid),
        .flags_q       (flags_q),
        .done          (done),
        .skipped       (skipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (sb && sd) sbsd_viol++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] f,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rd, input logic [63:0] imm,
                         input logic [1:0] cnd);
        cmd_op    = op;
        cmd_fs    = f;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_imm   = imm;
        cmd_cond  = cnd;
        cmd_c0    = 1'b0;
        cmd_valid = 1'b1;
    endtask

    function automatic logic [63:0] ctl();
        return 64'({addrA, addrB, addrR, fs, c0, s, w, sb, sd,
                    bus_in_req, bus_out_valid, flags_q, done, skipped});
    endfunction

    logic [1:0] q_op [3];
    logic [4:0] q_rb [3];
    logic [4:0] q_rd [3];
    int acyc [3];
    int dcyc [3];
    int na, nd, nw, nbad_after;
    logic rdy;
    logic exp_w;

    initial begin
        rst = 1'b1;
        issue(OP_ALU_RR, 5'd0, 5'd0, 5'd0, 5'd0, 64'd0, COND_ALWAYS);
        cmd_valid = 1'b0;
        status = 4'd0;
        #1 rst = 1'b0;
        #2;
        check("rst_ctl", ctl(), 64'd0);
        check("rst_k", k, 64'd0);
        check("rst_ready", cmd_ready, 1);
        #9 rst = 1'b1;
        tick;
        check("idle_ready", cmd_ready, 1);

        // ALU reg-reg, two EXEC cycles
        issue(OP_ALU_RR, FS_ADD, 5'd1, 5'd2, 5'd3, 64'd0, COND_ALWAYS);
        tick;
        cmd_valid = 1'b0;
        cmd_ra = 5'd9;
        cmd_rd = 5'd9;
        status = 4'b0010;
        check("rr_c1_a", addrA, 1);
        check("rr_c1_b", addrB, 2);
        check("rr_c1_s", s, 0);
        check("rr_c1_w", w, 0);
        check("rr_c1_fs", fs, 64'(FS_ADD));
        check("rr_c1_rdy", cmd_ready, 0);
        tick;
        check("rr_c2_a", addrA, 1);
        check("rr_c2_w", w, 0);
        check("rr_c2_flags", flags_q, 0);
        tick;
        status = 4'b1111;
        check("rr_wb_w", w, 1);
        check("rr_wb_sd", sd, 1);
        check("rr_wb_r", addrR, 3);
        check("rr_wb_a", addrA, 1);
        check("rr_flags", flags_q, 4'b0010);
        check("rr_wb_done", done, 0);
        tick;
        check("rr_done", done, 1);
        check("rr_done_w", w, 0);
        check("rr_done_rdy", cmd_ready, 1);
        check("rr_flags_hold", flags_q, 4'b0010);
        tick;
        check("rr_done_pulse", done, 0);

        // ALU reg-imm
        issue(OP_ALU_RI, FS_ADD, 5'd4, 5'd0, 5'd5, 64'h10, COND_ALWAYS);
        status = 4'b0001;
        tick;
        cmd_valid = 1'b0;
        cmd_imm = 64'hdead;
        check("ri_c1_s", s, 1);
        check("ri_c1_k", k, 64'h10);
        check("ri_c1_a", addrA, 4);
        tick;
        check("ri_c2_k", k, 64'h10);
        tick;
        check("ri_wb_s", s, 1);
        check("ri_wb_k", k, 64'h10);
        check("ri_wb_w", w, 1);
        check("ri_wb_r", addrR, 5);
        check("ri_flags", flags_q, 4'b0001);
        tick;
        check("ri_done", done, 1);
        tick;

        // LOAD then back-to-back STORE
        issue(OP_LOAD, 5'd0, 5'd0, 5'd0, 5'd7, 64'd0, COND_ALWAYS);
        status = 4'b1100;
        tick;
        check("ld_req", bus_in_req, 1);
        check("ld_w", w, 1);
        check("ld_r", addrR, 7);
        check("ld_sbsd", {sb, sd}, 0);
        issue(OP_STORE, 5'd0, 5'd0, 5'd7, 5'd0, 64'd0, COND_ALWAYS);
        tick;
        check("ld_done", done, 1);
        check("ld_done_req", bus_in_req, 0);
        check("ld_done_w", w, 0);
        check("ld_done_rdy", cmd_ready, 1);
        tick;
        cmd_valid = 1'b0;
        check("st_sb", sb, 1);
        check("st_bov", bus_out_valid, 1);
        check("st_b", addrB, 7);
        check("st_w", w, 0);
        check("st_sd", sd, 0);
        tick;
        check("st_done", done, 1);
        check("st_flags_hold", flags_q, 4'b0001);
        tick;

        // Three queued commands with cmd_valid held high
        q_op[0] = OP_LOAD;   q_rb[0] = 5'd0; q_rd[0] = 5'd1;
        q_op[1] = OP_STORE;  q_rb[1] = 5'd2; q_rd[1] = 5'd0;
        q_op[2] = OP_ALU_RR; q_rb[2] = 5'd0; q_rd[2] = 5'd3;
        na = 0; nd = 0; nw = 0;
        status = 4'd0;
        issue(q_op[0], FS_INC, 5'd0, q_rb[0], q_rd[0], 64'd0, COND_ALWAYS);
        for (int c = 0; c < 12; c++) begin
            if (done && nd < 3) begin
                dcyc[nd] = c;
                nd++;
            end
            if (w) nw++;
            rdy = cmd_ready;
            tick;
            if (rdy && cmd_valid && na < 3) begin
                acyc[na] = c;
                na++;
                if (na < 3)
                    issue(q_op[na], FS_INC, 5'd0, q_rb[na], q_rd[na],
                          64'd0, COND_ALWAYS);
                else
                    cmd_valid = 1'b0;
            end
        end
        check("q_accepts", na, 3);
        check("q_dones", nd, 3);
        check("q_writes", nw, 2);
        check("q_acc0", acyc[0], 0);
        check("q_acc1", acyc[1], 2);
        check("q_acc2", acyc[2], 4);
        check("q_done0", dcyc[0], 2);
        check("q_done1", dcyc[1], 4);
        check("q_done2", dcyc[2], 4 + EXEC + 2);

        // cond Z=1 while result nonzero (Z=0)
`ifdef ALU_SEQ_COND_EN
        exp_w = 1'b0;
`else
        exp_w = 1'b1;
`endif
        issue(OP_ALU_RR, FS_SUB, 5'd1, 5'd2, 5'd6, 64'd0, COND_Z);
        status = 4'b0000;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        check("cz_wb_w", w, 64'(exp_w));
        check("cz_wb_sd", sd, 64'(exp_w));
        tick;
        check("cz_done", done, 1);
        check("cz_skip", skipped, 64'(!exp_w));
        tick;
        check("cz_skip_pulse", skipped, 0);

        // cond C=1 with carry set writes back in either build
        issue(OP_ALU_RR, FS_ADD, 5'd1, 5'd2, 5'd8, 64'd0, COND_C);
        status = 4'b0010;
        tick;
        cmd_valid = 1'b0;
        tick;
        tick;
        check("cc_wb_w", w, 1);
        check("cc_wb_r", addrR, 8);
        tick;
        check("cc_skip", {done, skipped}, 2'b10);
        tick;

        // Async reset in the middle of EXEC
        issue(OP_ALU_RR, FS_OR, 5'd1, 5'd2, 5'd3, 64'd0, COND_ALWAYS);
        tick;
        cmd_valid = 1'b0;
        check("mr_pre_a", addrA, 1);
        #2 rst = 1'b0;
        #1;
        check("mr_ctl", ctl(), 64'd0);
        check("mr_k", k, 64'd0);
        check("mr_ready", cmd_ready, 1);
        #2 rst = 1'b1;
        nw = 0;
        nbad_after = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (w) nw++;
            if (done) nbad_after++;
        end
        check("mr_no_w", nw, 0);
        check("mr_no_done", nbad_after, 0);

        check("sb_sd_excl", sbsd_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Micro-sequencer that drives the control word of the register-file/ALU datapath (addrA/addrB/addrR, fs, s, k, c0, w, sb, sd).
- Accepts one command at a time over a valid/ready handshake and runs it in a fixed cycle sequence.
- Supported commands: ALU reg-reg, ALU reg-imm, bus LOAD into a register, bus STORE from a register.
- Captures ALU status into a flag register. Sits between the instruction/decode stage and the datapath. The datapath dout bus is looped back to din externally.

Parameters:
- EXEC_CYCLES, 1, ALU settle cycles before writeback (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_op  input  2  0 ALU_RR, 1 ALU_RI, 2 LOAD, 3 STORE
- cmd_fs  input  5  ALU function select
- cmd_c0  input  1  ALU carry-in
- cmd_ra, cmd_rb, cmd_rd  input  5 each  source A, source B, destination
- cmd_imm  input  64  immediate for ALU_RI
- cmd_cond  input  2  writeback condition (see Optional Feature)
- status  input  4  ALU status from datapath
- addrA, addrB, addrR  output  5 each  register addresses
- fs  output  5;  c0  output  1;  s  output  1 (1 selects k);  k  output  64
- w  output  1  register write
- sb  output  1  dataB bus enable;  sd  output  1  ALU-result bus enable
- bus_in_req  output  1  external agent must drive din this cycle
- bus_out_valid  output  1  dout carries register data this cycle
- flags_q  output  4  last captured ALU status
- done  output  1  one-cycle completion pulse
- skipped  output  1  pulses with done when writeback was suppressed

Behaviour:
- All outputs are registered. Reset (async assert, sync-released by clk) forces state IDLE and every output to 0, except cmd_ready=1.
- States: IDLE, EXEC, WB, BUS_IN, BUS_OUT.
- Accept on the rising edge where cmd_valid && cmd_ready; operands are latched internally at that edge.
- IDLE: all control outputs 0. On accept, go to EXEC (ALU ops), BUS_IN (LOAD) or BUS_OUT (STORE).
- EXEC:
  - Lasts EXEC_CYCLES cycles, counted by a 4-bit counter.
  - Drives addrA=ra, addrB=rb, fs, c0; s=1 and k=imm for ALU_RI, else s=0 and k=0.
  - w=sb=sd=0.
  - On the last EXEC cycle edge, flags_q <= status. Then go to WB.
- WB: one cycle. Holds the EXEC values and adds addrR=rd, sd=1, w=1. Then go to IDLE.
- BUS_IN: one cycle. addrR=rd, w=1, bus_in_req=1, sb=sd=0. Then go to IDLE.
- BUS_OUT: one cycle. addrB=rb, sb=1, bus_out_valid=1, w=0. Then go to IDLE.
- done=1 in the first IDLE cycle after WB/BUS_IN/BUS_OUT. cmd_ready is also 1 in that cycle, so back-to-back accept is legal.
- Latency from accept to done: ALU ops EXEC_CYCLES+2; LOAD and STORE 2.
- Invariants:
  - sb && sd never both 1.
  - w=1 only in WB or BUS_IN.
  - cmd_* ignored while cmd_ready=0.
- flags_q changes only at the end of EXEC; LOAD and STORE leave it untouched.
- Reset mid-operation (any state): outputs clear immediately, w drops so no write completes, the command is lost, and done does not pulse.

Optional Feature:
- Macro ALU_SEQ_COND_EN.
- Defined:
  - cmd_cond is latched at accept and evaluated in WB against flags_q, i.e. the flags just captured by this operation.
  - Conditions: 0 always, 1 Z=1, 2 Z=0, 3 C=1.
  - If the condition fails, WB drives w=0 and sd=0, and skipped=1 pulses with done.
  - LOAD and STORE ignore cmd_cond.
- Undefined: cmd_cond is ignored, writeback is unconditional, and skipped is tied 0.

Decomposition:
- Shared package holds:
  - op encodings (OP_ALU_RR, OP_ALU_RI, OP_LOAD, OP_STORE);
  - state enum;
  - status bit indices STAT_Z, STAT_C, STAT_N, STAT_V;
  - COND_* encodings;
  - FS_* function-select constants used by the bench.
- One natural sub-module, alu_seq_ctrl_cond, implementing combinational condition evaluation from flags_q and cond.

Test Plan:
- Reset: assert rst=0 mid-EXEC -> all outputs 0 and cmd_ready=1 asynchronously; after release no w pulse and no done.
- ALU_RR, EXEC_CYCLES=2, ra=1 rb=2 rd=3 fs=FS_ADD:
  - cycles 1-2 after accept: addrA=1, addrB=2, s=0, w=0;
  - cycle 3: w=1, sd=1, addrR=3;
  - cycle 4: done=1;
  - flags_q equals status sampled at the end of cycle 2.
- ALU_RI imm=64'h10, rd=5 -> s=1 and k=64'h10 through EXEC and WB; writeback to register 5.
- LOAD rd=7 followed by STORE rb=7:
  - LOAD: bus_in_req=1 with w=1 and addrR=7 for one cycle;
  - STORE: sb=1 with bus_out_valid=1 and addrB=7;
  - sb and sd are never both high anywhere in the trace.
- cmd_valid held high with 3 queued commands -> each accepted on its predecessor's done cycle; no dropped or duplicated commands.
- ALU_SEQ_COND_EN, cond=1, ALU result nonzero (Z=0) -> WB has w=0 and sd=0, done=1 with skipped=1, register unchanged.
